// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with active-low request/grant, one idle turnaround cycle per release.
// Optional forced release after MAX_HOLD grant cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_bus_arbiter #(
    parameter int N_MASTERS = 3,
    parameter int MAX_HOLD  = 16,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame,
    input  logic                 irdy,
    input  logic [N_MASTERS-1:0] req_n,
    output logic [N_MASTERS-1:0] gnt_n,
    output logic [IDX_W-1:0]     owner,
    output logic                 owner_vld,
    output logic                 timeout
);

    localparam int CW = IDX_W + 1;

    if (N_MASTERS < 2 || N_MASTERS > 16) begin : g_bad_n
        $error("rr_bus_arbiter: N_MASTERS out of range 2..16");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_bus_arbiter: MAX_HOLD out of range 2..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [IDX_W-1:0]     last, last_nx, win, owner_nx;
    logic [N_MASTERS-1:0] gnt_nx;
    logic                 vld_nx;
    logic                 any_req;
    logic                 done;
    logic                 hold_hit;

    assign done    = frame & irdy;
    assign any_req = ~&req_n;

    // First requester found scanning upward from from+1, wrapping at N_MASTERS.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] from,
                                                 input logic [N_MASTERS-1:0] rq_n);
        logic [CW-1:0]    cand;
        logic [IDX_W-1:0] w;
        logic             found;
        w     = from;
        found = 1'b0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = {1'b0, from} + CW'(k);
            if (cand >= CW'(N_MASTERS)) begin
                cand = cand - CW'(N_MASTERS);
            end
            if (!found && !rq_n[cand[IDX_W-1:0]]) begin
                w     = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win = rr_pick(last, req_n);

    always_comb begin
        state_nx = state;
        gnt_nx   = '1;
        owner_nx = owner;
        vld_nx   = 1'b0;
        last_nx  = last;
        case (state)
            GRANT: begin
                if (done || hold_hit) begin
                    state_nx = RELEASE;
                end else begin
                    gnt_nx = gnt_n;
                    vld_nx = 1'b1;
                end
            end
            default: begin
                // IDLE and RELEASE share the same selection.
                if (any_req) begin
                    state_nx = GRANT;
                    gnt_nx   = ~(N_MASTERS'(1) << win);
                    owner_nx = win;
                    vld_nx   = 1'b1;
                    last_nx  = win;
                end else begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt_n     <= '1;
            owner     <= '0;
            owner_vld <= 1'b0;
            last      <= IDX_W'(N_MASTERS - 1);
        end else begin
            state     <= state_nx;
            gnt_n     <= gnt_nx;
            owner     <= owner_nx;
            owner_vld <= vld_nx;
            last      <= last_nx;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign hold_hit = (state == GRANT) && (hold_cnt == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state != GRANT && state_nx == GRANT) begin
                hold_cnt <= '0;
            end else if (state == GRANT && !done) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
            // done on the same edge wins: that is a normal release.
            timeout <= hold_hit && !done;
        end
    end
`else
    assign hold_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter: a transaction-level model predicts each cycle's grant outputs.
module tb_rr_bus_arbiter;

    localparam int N    = 3;
    localparam int N5   = 5;
    localparam int MAXH = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          frame;
    logic          irdy;
    logic [N-1:0]  req_n;
    logic [N-1:0]  gnt_n;
    logic [1:0]    owner;
    logic          owner_vld;
    logic          timeout;
    logic [N5-1:0] req5_n;
    logic [N5-1:0] gnt5_n;
    logic [2:0]    owner5;
    logic          vld5;
    logic          tmo5;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.N_MASTERS(N), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .reset(reset), .frame(frame), .irdy(irdy), .req_n(req_n),
        .gnt_n(gnt_n), .owner(owner), .owner_vld(owner_vld), .timeout(timeout)
    );

    rr_bus_arbiter #(.N_MASTERS(N5), .MAX_HOLD(MAXH)) dut5 (
        .clk(clk), .reset(reset), .frame(frame), .irdy(irdy), .req_n(req5_n),
        .gnt_n(gnt5_n), .owner(owner5), .owner_vld(vld5), .timeout(tmo5)
    );

    typedef struct packed {
        logic [N-1:0] gnt_n;
        logic [1:0]   owner;
        logic         vld;
        logic         tmo;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Transaction-level model: bus busy or free, who owns it, who was granted last.
    bit m_busy;
    int m_cur;
    int m_last;
    int m_held;

    function automatic int rr_pick(input int from, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (from + k) % N;
            if (r[idx] == 1'b0) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_cur  = 0;
        m_last = N - 1;
        m_held = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input bit d);
        exp_t e;
        bit   tmo;
        int   w;
        tmo = 1'b0;
        if (m_busy) begin
            if (d) begin
                m_busy = 1'b0;
            end else if (TMO_EN && m_held == MAXH - 1) begin
                m_busy = 1'b0;
                tmo    = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            w = rr_pick(m_last, r);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_cur  = w;
                m_last = w;
                m_held = 0;
            end
        end
        e.gnt_n = m_busy ? ~(3'(1) << m_cur) : '1;
        e.owner = 2'(m_cur);
        e.vld   = m_busy;
        e.tmo   = tmo;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic f, input logic i);
        req_n = r;
        frame = f;
        irdy  = i;
        @(posedge clk);
        model_edge(r, f && i);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (gnt_n !== e.gnt_n || owner_vld !== e.vld || owner !== e.owner || timeout !== e.tmo) begin
                errors++;
                $display("FAIL cycle: got gnt_n=%b owner=%0d vld=%b tmo=%b expected gnt_n=%b owner=%0d vld=%b tmo=%b at %0t",
                         gnt_n, owner, owner_vld, timeout, e.gnt_n, e.owner, e.vld, e.tmo, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        req_n  = '1;
        req5_n = '1;
        frame  = 1'b0;
        irdy   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt_n, 3'b111);
        chk("rst_owner", owner, 0);
        chk("rst_vld", owner_vld, 0);
        chk("rst_tmo", timeout, 0);
        chk("rst_gnt5", gnt5_n, 5'b11111);
        reset = 1'b0;

        // Single master 0, done on the 4th grant cycle; N=5 wrap from last=4.
        req5_n = 5'b01110;
        step(3'b110, 0, 0);
        chk("first_gnt", gnt_n, 3'b110);
        chk("wrap5_gnt", gnt5_n, 5'b11110);
        chk("wrap5_owner", owner5, 0);
        repeat (3) step(3'b110, 0, 0);
        step(3'b111, 1, 1);
        chk("rel_gnt", gnt_n, 3'b111);
        chk("rel5_gnt", gnt5_n, 5'b11111);
        step(3'b111, 0, 0);
        chk("wrap5_next_gnt", gnt5_n, 5'b01111);
        chk("wrap5_next_owner", owner5, 4);
        req5_n = '1;
        step(3'b111, 1, 1);
        step(3'b111, 0, 0);

        // All requesting, done every 3rd grant cycle: strict rotation.
        for (int g = 0; g < 6; g++) begin
            step(3'b000, 0, 0);
            chk("rr_order", owner, (g + 1) % N);
            step(3'b000, 0, 0);
            step(3'b000, 0, 0);
            step(3'b000, 1, 1);
            chk("rr_gap", gnt_n, 3'b111);
        end

        // Master 1 withdraws its request but keeps the bus until done.
        step(3'b101, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(3'b111, 0, 0);
            chk("hold_after_drop", gnt_n, 3'b101);
        end
        step(3'b111, 1, 1);
        step(3'b111, 0, 0);

        // Asynchronous reset in the middle of master 1's grant.
        step(3'b101, 0, 0);
        step(3'b101, 0, 0);
        chk("pre_rst_gnt", gnt_n, 3'b101);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_gnt", gnt_n, 3'b111);
        chk("async_rst_vld", owner_vld, 0);
        q.delete();
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        step(3'b000, 0, 0);
        chk("post_rst_owner", owner, 0);
        step(3'b000, 1, 1);
        step(3'b111, 0, 0);

`ifdef RR_ARB_TIMEOUT_EN
        // Master 2 never completes: forced release after MAXH grant cycles.
        step(3'b011, 0, 0);
        repeat (3) step(3'b011, 0, 0);
        chk("tmo_still_gnt", gnt_n, 3'b011);
        step(3'b000, 0, 0);
        chk("tmo_pulse", timeout, 1);
        chk("tmo_rel_gnt", gnt_n, 3'b111);
        step(3'b000, 0, 0);
        chk("tmo_next_owner", owner, 0);
        chk("tmo_clear", timeout, 0);
        step(3'b111, 1, 1);
        step(3'b111, 0, 0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] rv;
            rv = $urandom;
            step(rv[2:0], ($urandom % 4) != 0, ($urandom % 3) == 0);
        end

        step(3'b111, 1, 1);
        step(3'b111, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
